// File: rtl/grant_issue.sv
// grant_issue: turns a one-hot selection into a registered grant, offers it
// until acknowledged, then holds it for HOLD service cycles. A pending normal
// grant may be replaced once by an urgent selection while it is still offered.
module grant_issue #(
   parameter int N    = 8,
   parameter int W    = 3,
   parameter int HOLD = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sel,
   input  logic         sel_valid,
   input  logic         sel_valid_urgent,
   input  logic         grant_ack,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         grant_valid,
   output logic         grant_urgent,
   output logic         busy,
   output logic         done_pulse,
   output logic [7:0]   grant_cnt,
   output logic [7:0]   preempt_cnt,
   output logic         sel_err
);

   typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

   // Counter reload value: the first service cycle already reads HOLD-1.
   localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

   state_t         state;
   logic [7:0]     svc_cnt;
   logic           sel_any;
   logic           sel_onehot;
   logic [W-1:0]   sel_idx;

   // Decode the incoming selection: any-valid, exactly-one-hot, binary index.
   always_comb begin
      sel_any    = sel_valid | sel_valid_urgent;
      sel_onehot = (sel != '0) && ((sel & (sel - {{(N-1){1'b0}}, 1'b1})) == '0);
      sel_idx    = '0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) sel_idx = W'(i);
      end
   end

   // Grant FSM with all outputs registered; reset overrides every input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         svc_cnt      <= '0;
         grant        <= '0;
         grant_idx    <= '0;
         grant_valid  <= 1'b0;
         grant_urgent <= 1'b0;
         busy         <= 1'b0;
         done_pulse   <= 1'b0;
         grant_cnt    <= '0;
         preempt_cnt  <= '0;
         sel_err      <= 1'b0;
      end else begin
         // A malformed selection is flagged in every state and never used.
         if (sel_any && !sel_onehot) sel_err <= 1'b1;
         done_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_any && sel_onehot) begin
                  state        <= OFFER;
                  grant        <= sel;
                  grant_idx    <= sel_idx;
                  grant_urgent <= sel_valid_urgent;
                  grant_valid  <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            OFFER: begin
               // Ack wins over a simultaneous urgent preemption.
               if (grant_ack) begin
                  state       <= SERVICE;
                  grant_valid <= 1'b0;
                  svc_cnt     <= HOLD_M1;
                  grant_cnt   <= grant_cnt + 8'd1;
                  done_pulse  <= (HOLD_M1 == 8'd0);
               end else if (!grant_urgent && sel_valid_urgent && sel_onehot &&
                            (sel_idx != grant_idx)) begin
                  grant        <= sel;
                  grant_idx    <= sel_idx;
                  grant_urgent <= 1'b1;
                  if (preempt_cnt != 8'hFF) preempt_cnt <= preempt_cnt + 8'd1;
               end
            end
            SERVICE: begin
               // done_pulse is raised on the edge that brings the counter to 0.
               if (svc_cnt == 8'd0) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  grant        <= '0;
                  grant_idx    <= '0;
                  grant_urgent <= 1'b0;
               end else begin
                  svc_cnt    <= svc_cnt - 8'd1;
                  done_pulse <= (svc_cnt == 8'd1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/grant_issue.md
GRANT_ISSUE -- requirements
Module: grant_issue

Interface
REQ-001 Parameter N, default 8: requester count; equals the width of the selector's one-hot output.
REQ-002 Parameter W, default 3: index width, equal to log2(N).
REQ-003 Parameter HOLD, default 4: service cycles per accepted grant; legal range 1..255.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 sel  input  N  one-hot selection from the upstream priority selector.
REQ-008 sel_valid  input  1  sel carries a normal or urgent selection.
REQ-009 sel_valid_urgent  input  1  sel was chosen from the urgent vector.
REQ-010 grant_ack  input  1  consumer accepts the current grant.
REQ-011 grant  output  N  registered one-hot grant.
REQ-012 grant_idx  output  W  binary index of grant.
REQ-013 grant_valid  output  1  grant offered, awaiting ack.
REQ-014 grant_urgent  output  1  current grant is urgent.
REQ-015 busy  output  1  FSM not in IDLE.
REQ-016 done_pulse  output  1  one-cycle pulse on the last service cycle.
REQ-017 grant_cnt  output  8  accepted grants, wrapping.
REQ-018 preempt_cnt  output  8  urgent preemptions, saturating.
REQ-019 sel_err  output  1  sticky flag for a malformed selection.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, OFFER and SERVICE.
REQ-021 In IDLE, with sel_valid=1 and sel exactly one-hot, sel, its index and sel_valid_urgent SHALL be captured, and the FSM SHALL enter OFFER on the next edge (one-cycle latency to grant_valid).
REQ-022 A selection SHALL count as urgent when sel_valid_urgent=1, regardless of sel_valid.
REQ-023 In any state, sel all-zero or multi-hot with sel_valid=1 SHALL set sel_err to 1 (held until rst), and the selection SHALL be ignored.
REQ-024 sel_valid_urgent=1 without sel_valid SHALL be treated as urgent-valid; this is not an error.
REQ-025 grant_valid SHALL be 1 only in OFFER; grant, grant_idx and grant_urgent SHALL hold stable from capture until the FSM returns to IDLE.
REQ-026 In OFFER, grant_ack=1 SHALL move the FSM to SERVICE, load the service counter with HOLD-1, and increment grant_cnt (255 wraps to 0).
REQ-027 In OFFER with grant_urgent=0, an urgent one-hot selection whose index differs from grant_idx, together with grant_ack=0, SHALL replace the grant (grant_urgent becomes 1) and increment preempt_cnt (saturating at 255); the FSM SHALL stay in OFFER.
REQ-028 When grant_ack=1 and an urgent preemption occur in the same cycle, the ack SHALL win: the current grant enters SERVICE and the urgent selection is dropped.
REQ-029 An urgent grant SHALL never be preempted; an urgent selection naming the current grant_idx SHALL cause no change.
REQ-030 grant_ack outside OFFER SHALL be ignored.
REQ-031 In SERVICE, the counter SHALL decrement each cycle; the cycle it reads 0 SHALL assert done_pulse, and the next edge SHALL return to IDLE.
REQ-032 With HOLD=1, done_pulse SHALL assert in the first SERVICE cycle.
REQ-033 Selections in SERVICE SHALL be ignored; they are not queued.
REQ-034 busy SHALL be 1 in OFFER and SERVICE.
REQ-035 In IDLE, grant, grant_idx and grant_urgent SHALL read 0.

Reset
REQ-036 rst=1 at an edge SHALL force IDLE from any state, including mid-OFFER and mid-SERVICE.
REQ-037 At that edge, grant, grant_idx, grant_valid, grant_urgent, busy, done_pulse, grant_cnt, preempt_cnt, the service counter and sel_err SHALL all become 0.
REQ-038 rst SHALL take priority over every other input in the same cycle.
REQ-039 The first capture SHALL be possible in the first cycle with rst=0.

Verification
REQ-040 Normal grant: sel=8'b00000100, sel_valid=1 in IDLE; ack two cycles later -> grant_valid=1 at t+1, grant_idx=2; done_pulse 4 cycles after the ack edge; grant_cnt=1.
REQ-041 Preemption: normal grant idx 5 in OFFER; sel=8'b00001000, sel_valid_urgent=1, no ack -> grant_idx=3, grant_urgent=1, preempt_cnt=1.
REQ-042 Ack/urgent collision: same as REQ-041 but grant_ack=1 in that cycle -> SERVICE with idx 5, preempt_cnt=0.
REQ-043 Malformed selection: sel=8'b00111000, sel_valid=1 -> sel_err=1, FSM stays IDLE, grant_cnt unchanged.
REQ-044 Reset mid-SERVICE with grant_cnt=255: one more grant gives 0 (wrap); rst asserted in SERVICE -> all outputs 0 next cycle.
REQ-045 HOLD=1 back-to-back: continuous sel_valid and ack -> one grant every 3 cycles, with done_pulse in every SERVICE cycle.
